// File: rtl/pyjamask96_pkg.sv
// Shared constants, FSM encoding and GF(2) helpers for the Pyjamask-96 key schedule.
// The MixRows multiplier build is selected by PYJ96_KS_PARALLEL_MULT_EN (see pyjamask96_circ_mult).
package pyjamask96_pkg;

   localparam logic [31:0] COL_MK = 32'hb881b9ca;

   localparam logic [31:0] RC0 = 32'h0000_0080;
   localparam logic [31:0] RC1 = 32'h0000_6a00;
   localparam logic [31:0] RC2 = 32'h003f_0000;
   localparam logic [31:0] RC3 = 32'h2400_0000;

   localparam int ROT1 = 8;
   localparam int ROT2 = 15;
   localparam int ROT3 = 18;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_READY  = 3'd2;
   localparam logic [2:0] ST_MIXCOL = 3'd3;
   localparam logic [2:0] ST_MULT   = 3'd4;
   localparam logic [2:0] ST_FINAL  = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;

   function automatic logic [31:0] rol32(input logic [31:0] x, input int n);
      return (n % 32 == 0) ? x : ((x << (n % 32)) | (x >> (32 - (n % 32))));
   endfunction

   function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
      return (n % 32 == 0) ? x : ((x >> (n % 32)) | (x << (32 - (n % 32))));
   endfunction

   // Circulant product: operand bit 31-i selects COL_MK rotated right by i.
   function automatic logic [31:0] circ_mul32(input logic [31:0] a);
      logic [31:0] acc;
      acc = '0;
      for (int i = 0; i < 32; i++)
         if (a[31-i]) acc = acc ^ ror32(COL_MK, i);
      return acc;
   endfunction

endpackage

// File: rtl/pyjamask96_key_schedule_if.sv
// Key-load and round-key handshake bundle of the Pyjamask-96 key schedule.
interface pyjamask96_key_schedule_if;
   logic        key_load;
   logic [7:0]  byte_key_in;
   logic        rk_ready;
   logic        rk_valid;
   logic [95:0] rk;
   logic [3:0]  rk_idx;
   logic        rk_last;
   logic        busy;

   modport master (
      output key_load, byte_key_in, rk_ready,
      input  rk_valid, rk, rk_idx, rk_last, busy
   );

   modport slave (
      input  key_load, byte_key_in, rk_ready,
      output rk_valid, rk, rk_idx, rk_last, busy
   );
endinterface

// File: rtl/pyjamask96_circ_mult.sv
// Circulant (COL_MK) multiplier: bit-serial over 32 steps, or one step when
// PYJ96_KS_PARALLEL_MULT_EN is defined. load captures op; res is valid after the step where last is high.
module pyjamask96_circ_mult
   import pyjamask96_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] op,
   output logic [31:0] res,
   output logic        last
);

`ifdef PYJ96_KS_PARALLEL_MULT_EN
   logic [31:0] opnd;
   logic [31:0] acc;

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         opnd <= '0;
         acc  <= '0;
      end else if (load) begin
         opnd <= op;
         acc  <= '0;
      end else if (step) begin
         acc  <= circ_mul32(opnd);
      end
   end

   assign res  = acc;
   assign last = 1'b1;
`else
   logic [31:0] opnd;
   logic [31:0] mask;
   logic [31:0] acc;
   logic [4:0]  cnt;

   // opnd shifts left so its MSB is the current bit; mask tracks ror(COL_MK, cnt).
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         opnd <= '0;
         mask <= '0;
         acc  <= '0;
         cnt  <= '0;
      end else if (load) begin
         opnd <= op;
         mask <= COL_MK;
         acc  <= '0;
         cnt  <= '0;
      end else if (step) begin
         acc  <= acc ^ (opnd[31] ? mask : 32'h0);
         opnd <= {opnd[30:0], 1'b0};
         mask <= ror32(mask, 1);
         cnt  <= cnt + 5'd1;
      end
   end

   assign res  = acc;
   assign last = (cnt == 5'd31);
`endif

endmodule

// File: rtl/pyjamask96_key_schedule.sv
// Pyjamask-96 key schedule: byte-serial key load, then one round key per handshake.
// PYJ96_KS_PARALLEL_MULT_EN selects the single-cycle MixRows multiplier.
module pyjamask96_key_schedule
   import pyjamask96_pkg::*;
#(
   parameter int NB_ROUNDS = 14
)
(
   input logic clk,
   input logic reset_n,
   pyjamask96_key_schedule_if.slave ks
);

   localparam logic [3:0] LAST_IDX = 4'(NB_ROUNDS);

   logic [2:0]   state;
   logic [127:0] key;
   logic [4:0]   byte_cnt;
   logic [3:0]   rk_idx;
   logic [31:0]  row0, row1, row2, row3;
   logic [31:0]  t;
   logic [31:0]  mult_op;
   logic [31:0]  mult_res;
   logic         mult_load, mult_step, mult_last;

   assign {row0, row1, row2, row3} = key;
   assign t = row0 ^ row1 ^ row2 ^ row3;

   // Mixed row0 (row0 ^ t) reduces to the XOR of the other three rows.
   assign mult_op   = row1 ^ row2 ^ row3;
   assign mult_load = (state == ST_MIXCOL) && !ks.key_load;
   assign mult_step = (state == ST_MULT) && !ks.key_load;

   pyjamask96_circ_mult u_mult (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (mult_load),
      .step    (mult_step),
      .op      (mult_op),
      .res     (mult_res),
      .last    (mult_last)
   );

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state    <= ST_IDLE;
         key      <= '0;
         byte_cnt <= '0;
         rk_idx   <= '0;
      end else if (ks.key_load) begin
         // A byte from any state aborts whatever was running; a 17th byte starts a new key.
         key      <= {key[119:0], ks.byte_key_in};
         byte_cnt <= (state == ST_LOAD && byte_cnt != 5'd16) ? byte_cnt + 5'd1 : 5'd1;
         rk_idx   <= '0;
         state    <= ST_LOAD;
      end else begin
         case (state)
            ST_LOAD:
               if (byte_cnt == 5'd16) state <= ST_READY;
            ST_READY:
               if (ks.rk_ready) state <= (rk_idx == LAST_IDX) ? ST_DONE : ST_MIXCOL;
            ST_MIXCOL: begin
               key   <= {row0 ^ t, row1 ^ t, row2 ^ t, row3 ^ t};
               state <= ST_MULT;
            end
            ST_MULT:
               if (mult_last) state <= ST_FINAL;
            ST_FINAL: begin
               key    <= {mult_res ^ RC0 ^ {28'd0, rk_idx},
                          rol32(row1, ROT1) ^ RC1,
                          rol32(row2, ROT2) ^ RC2,
                          rol32(row3, ROT3) ^ RC3};
               rk_idx <= rk_idx + 4'd1;
               state  <= ST_READY;
            end
            default: ;
         endcase
      end
   end

   assign ks.rk       = key[127:32];
   assign ks.rk_idx   = rk_idx;
   assign ks.rk_valid = (state == ST_READY);
   assign ks.rk_last  = (rk_idx == LAST_IDX);
   assign ks.busy     = (state == ST_MIXCOL) || (state == ST_MULT) || (state == ST_FINAL);

endmodule

// File: tb/tb_pyjamask96_key_schedule.sv
// Self-checking bench for pyjamask96_key_schedule: random keys against a round-key model.
module tb_pyjamask96_key_schedule;

   localparam int NR = 14;
`ifdef PYJ96_KS_PARALLEL_MULT_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 34;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   logic [95:0] exp_rk [0:NR];
   logic [95:0] obs    [0:NR];

   pyjamask96_key_schedule_if ks_if ();

   pyjamask96_key_schedule #(.NB_ROUNDS(NR)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ks      (ks_if.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
      logic [63:0] d;
      d = {x, x} << n;
      return d[63:32];
   endfunction

   // Round keys straight from the algorithm: mix columns, multiply row0 by the
   // circulant matrix built from 0xb881b9ca, rotate rows, add constants.
   function automatic void build_model(input logic [127:0] k);
      logic [31:0] r [4];
      logic [31:0] t, m, col;
      for (int i = 0; i < 4; i++) r[i] = k[127-32*i -: 32];
      exp_rk[0] = {r[0], r[1], r[2]};
      for (int j = 0; j < NR; j++) begin
         t = r[0] ^ r[1] ^ r[2] ^ r[3];
         for (int i = 0; i < 4; i++) r[i] = r[i] ^ t;
         m = 32'h0;
         for (int i = 0; i < 32; i++) begin
            col = rotl(32'hb881b9ca, 32 - i);
            if (r[0][31-i]) m = m ^ col;
         end
         r[0] = m ^ 32'h80 ^ 32'(j);
         r[1] = rotl(r[1], 8)  ^ 32'h00006a00;
         r[2] = rotl(r[2], 15) ^ 32'h003f0000;
         r[3] = rotl(r[3], 18) ^ 32'h24000000;
         exp_rk[j+1] = {r[0], r[1], r[2]};
      end
   endfunction

   task automatic load_key(input logic [127:0] k);
      for (int i = 0; i < 16; i++) begin
         ks_if.key_load    = 1'b1;
         ks_if.byte_key_in = k[127-8*i -: 8];
         tick();
      end
      ks_if.key_load    = 1'b0;
      ks_if.byte_key_in = 8'h00;
   endtask

   // Load a key and walk all round keys; cont holds rk_ready high throughout.
   task automatic run_key(input logic [127:0] k, input bit cont);
      int lat;
      build_model(k);
      for (int j = 0; j <= NR; j++) obs[j] = 'x;
      ks_if.rk_ready = cont;
      load_key(k);
      tick();
      for (int j = 0; j <= NR; j++) begin
         if (j > 0) begin
            lat = 0;
            while (!ks_if.rk_valid && lat < 200) begin
               tick();
               lat++;
            end
            chk("latency", 128'(lat), 128'(LAT));
            if (!ks_if.rk_valid) begin
               ks_if.rk_ready = 1'b0;
               return;
            end
         end
         chk("rk_valid", ks_if.rk_valid, 1);
         chk("rk", ks_if.rk, exp_rk[j]);
         chk("rk_idx", ks_if.rk_idx, 128'(j));
         chk("rk_last", ks_if.rk_last, 128'(j == NR));
         obs[j] = ks_if.rk;
         if (!cont) begin
            repeat ($urandom_range(0, 2)) begin
               tick();
               chk("rk_hold", ks_if.rk, exp_rk[j]);
               chk("valid_hold", ks_if.rk_valid, 1);
            end
            ks_if.rk_ready = 1'b1;
         end
         tick();
         ks_if.rk_ready = cont;
         chk("valid_drop", ks_if.rk_valid, 0);
         chk("busy_after_hs", ks_if.busy, 128'(j < NR));
      end
      chk("done_rk", ks_if.rk, exp_rk[NR]);
      repeat (3) tick();
      chk("done_valid", ks_if.rk_valid, 0);
      chk("done_busy", ks_if.busy, 0);
      ks_if.rk_ready = 1'b0;
   endtask

   initial begin
      logic [127:0] ka, kb;
      ks_if.key_load    = 1'b0;
      ks_if.byte_key_in = 8'h00;
      ks_if.rk_ready    = 1'b0;

      repeat (3) tick();
      reset_n = 1'b0;
      tick();
      chk("rst_valid", ks_if.rk_valid, 0);
      chk("rst_rk", ks_if.rk, 0);
      chk("rst_idx", ks_if.rk_idx, 0);
      chk("rst_busy", ks_if.busy, 0);
      chk("rst_last", ks_if.rk_last, 0);

      run_key(128'h0, 1'b0);
      chk("zero_rk0", obs[0], 96'h0);
      chk("zero_rk1", obs[1], 96'h00000080_00006a00_003f0000);

      run_key({4{32'h80000000}}, 1'b0);
      chk("msb_rk0", obs[0], 96'h80000000_80000000_80000000);
      chk("msb_rk1", obs[1], 96'hb881b94a_00006a80_003f4000);

      run_key({$urandom, $urandom, $urandom, $urandom}, 1'b1);

      // Abort: new key bytes while the multiplier is running.
      ka = {$urandom, $urandom, $urandom, $urandom};
      kb = {$urandom, $urandom, $urandom, $urandom};
      load_key(ka);
      tick();
      chk("abort_rk0", ks_if.rk, ka[127:32]);
      ks_if.rk_ready = 1'b1;
      tick();
      ks_if.rk_ready = 1'b0;
      tick();
      chk("abort_busy", ks_if.busy, 1);
      run_key(kb, 1'b0);

      // Reset mid-multiply returns to IDLE and needs a full reload.
      load_key(ka);
      tick();
      ks_if.rk_ready = 1'b1;
      tick();
      ks_if.rk_ready = 1'b0;
      tick();
      chk("mult_busy", ks_if.busy, 1);
      #2 reset_n = 1'b1;
      #1;
      chk("arst_valid", ks_if.rk_valid, 0);
      chk("arst_busy", ks_if.busy, 0);
      chk("arst_rk", ks_if.rk, 0);
      chk("arst_idx", ks_if.rk_idx, 0);
      tick();
      reset_n = 1'b0;
      repeat (40) tick();
      chk("idle_valid", ks_if.rk_valid, 0);
      chk("idle_busy", ks_if.busy, 0);

      repeat (2) run_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pyjamask96_key_schedule.md
PYJAMASK96_KEY_SCHEDULE -- requirements
Module: pyjamask96_key_schedule

Interface
REQ-001 SHALL have parameter NB_ROUNDS, default 14, meaning the number of cipher rounds; round keys rk0..rkNB_ROUNDS are produced.
REQ-002 SHALL have port clk  input  1  system clock, rising-edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port key_load  input  1  qualifies byte_key_in for one key byte.
REQ-005 SHALL have port byte_key_in  input  8  master key byte, MSB-first (first byte = key bits 127:120 = row0 bits 31:24).
REQ-006 SHALL have port rk_ready  input  1  consumer accepts the current round key.
REQ-007 SHALL have port rk_valid  output  1  rk holds a valid round key.
REQ-008 SHALL have port rk  output  96  round key = key-state rows 0,1,2 ({row0,row1,row2}).
REQ-009 SHALL have port rk_idx  output  4  index of the round key on rk.
REQ-010 SHALL have port rk_last  output  1  high while rk_idx == NB_ROUNDS.
REQ-011 SHALL have port busy  output  1  high in MIXCOL, MULT and FINAL.

Function
REQ-012 SHALL hold a 128-bit key state of four 32-bit rows; row0 = bits 127:96.
REQ-013 SHALL implement FSM states IDLE, LOAD, READY, MIXCOL, MULT, FINAL and DONE.
REQ-014 SHALL, on key_load in any state, shift byte_key_in into the key state LSB side, increment an internal byte count, and enter LOAD; key_load outside LOAD restarts the count at 1.
REQ-015 SHALL, when the 16th byte is captured, enter READY on the next edge with rk_idx=0, rk_valid=1, and rk = master key bits 127:32.
REQ-016 SHALL complete a handshake when rk_valid & rk_ready are high at a clock edge; rk, rk_idx and rk_valid SHALL hold stable until then.
REQ-017 SHALL, on handshake in READY with rk_idx < NB_ROUNDS, drop rk_valid and enter MIXCOL; with rk_idx == NB_ROUNDS it SHALL enter DONE with rk_valid=0.
REQ-018 SHALL, in MIXCOL (1 cycle), compute t = row0^row1^row2^row3 and XOR t into every row.
REQ-019 SHALL, in MULT, replace row0 by the circulant product: XOR over i=0..31 of (bit 31-i of row0 ? ror(0xb881b9ca, i) : 0), evaluated one bit per cycle over 32 cycles using a 5-bit counter.
REQ-020 SHALL, in FINAL (1 cycle), rotate left row1 by 8, row2 by 15 and row3 by 18; XOR in the constants row0 ^= 0x00000080 ^ r, row1 ^= 0x00006a00, row2 ^= 0x003f0000 and row3 ^= 0x24000000, where r = old rk_idx; increment rk_idx; and enter READY.
REQ-021 SHALL assert rk_valid exactly 34 cycles after the handshake edge (default build).
REQ-022 SHALL ignore rk_ready outside READY; key_load during MIXCOL/MULT/FINAL SHALL abort the computation.
REQ-023 SHALL remain in DONE until key_load, with rk_valid=0 and rk holding its last value.

Reset
REQ-024 SHALL, while reset_n is high, asynchronously clear the FSM to IDLE and clear the key state, byte count, multiply counter, rk_idx, rk_valid, rk_last and busy.
REQ-025 SHALL, on reset mid-load or mid-round, discard all partial state; a full 16-byte reload SHALL be required afterward.

Configuration
REQ-026 SHALL, when macro PYJ96_KS_PARALLEL_MULT_EN is defined, compute the whole circulant product in MULT in a single cycle, giving a handshake-to-rk_valid latency of 3 cycles.
REQ-027 SHALL, without PYJ96_KS_PARALLEL_MULT_EN, use the 32-cycle bit-serial multiply with latency 34; rk values SHALL be identical in both builds.

Structure
REQ-028 SHALL take the constants COL_MK (0xb881b9ca), the four row constants, the rotation amounts and the FSM state encoding from shared package pyjamask96_pkg.
REQ-029 SHALL place the circulant multiplier (serial or parallel per the macro) in sub-module pyjamask96_circ_mult, reusable by the MixRows datapath.

Verification
REQ-030 SHALL verify: reset high then release -> rk_valid=0, rk=0, rk_idx=0, busy=0.
REQ-031 SHALL verify: 16 zero bytes loaded -> rk0=0; after handshake, rk_valid 34 cycles later with rk = 0x00000080_00006a00_003f0000 and rk_idx=1.
REQ-032 SHALL verify: key rows all 0x80000000 -> rk1 = 0xb881b94a_00006a80_003f4000.
REQ-033 SHALL verify: rk_ready held high continuously -> 15 keys delivered, rk_last is high only with rk_idx=14, then DONE with rk_valid=0.
REQ-034 SHALL verify: key_load asserted in MULT, then 16 new bytes -> abort and rk0 = new key bits 127:32; also reset asserted mid-MULT -> IDLE.
REQ-035 SHALL verify: PYJ96_KS_PARALLEL_MULT_EN build -> same rk sequence as the default build with 3-cycle latency.
